// File: rtl/gecko_pkg.sv
// rtl/gecko_pkg.sv - shared types for the gecko_nano run controller
//
// Purpose: run status enum and result record exchanged between the run
//          controller and the host/test harness.
// Ports:   none (package).

package gecko_pkg;

  // Width of the cycles field carried in a result record.
  localparam int unsigned GECKO_RUN_CYCLES_W = 32;

  typedef enum logic [1:0] {
    RUN_EXIT    = 2'd0,
    RUN_ERROR   = 2'd1,
    RUN_TIMEOUT = 2'd2,
    RUN_ABORTED = 2'd3
  } gecko_run_status_t;

  typedef struct packed {
    gecko_run_status_t               status;
    logic [7:0]                      exit_code;
    logic [GECKO_RUN_CYCLES_W-1:0]   cycles;
  } gecko_run_result_t;

endpackage

// File: rtl/gecko_run_counter.sv
// rtl/gecko_run_counter.sv - loadable saturating up-counter with clear and enable
//
// Purpose: counts up by one per enabled cycle and sticks at all-ones.
//          Priority: clr > load > en.
// Ports:
//   clk, rst      system clock, synchronous active-low reset
//   clr           force count to zero
//   load          load load_value
//   load_value    value taken on load
//   en            increment (saturating)
//   count         registered count
//   count_next    value the counter takes at the next edge

module gecko_run_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/gecko_run_controller.sv
// rtl/gecko_run_controller.sv - sequences one program run of a gecko_nano core
//
// Purpose: accepts a start, holds the core in reset for RESET_CYCLES, runs it
//          while watching error/exit/abort/watchdog, drains tty output after
//          an exit, then presents one result record until consumed.
// Ports:
//   clk, rst                      system clock, synchronous active-low reset
//   start_valid/start_ready       start handshake (ready only in IDLE)
//   start_timeout                 RUN-cycle budget, 0 disables the watchdog
//   abort                         level abort request
//   core_rst                      active-high reset to the core
//   core_exit_flag/_error_flag    core status flags (honoured in RUN only)
//   core_exit_code                core exit code
//   tty_out_valid                 observed core tty output activity
//   result_valid/result_ready     result handshake
//   result_status/_exit_code/_cycles  result record
//   busy                          high in any state other than IDLE

module gecko_run_controller
  import gecko_pkg::*;
#(
  parameter int unsigned RESET_CYCLES      = 16,
  parameter int unsigned COUNT_WIDTH       = 32,
  parameter int unsigned DRAIN_IDLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [COUNT_WIDTH-1:0] start_timeout,
  input  logic                   abort,
  output logic                   core_rst,
  input  logic                   core_exit_flag,
  input  logic                   core_error_flag,
  input  logic [7:0]             core_exit_code,
  input  logic                   tty_out_valid,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [1:0]             result_status,
  output logic [7:0]             result_exit_code,
  output logic [COUNT_WIDTH-1:0] result_cycles,
  output logic                   busy
);

  localparam int unsigned RST_W  = $clog2(RESET_CYCLES + 1);
  localparam int unsigned IDLE_W = $clog2(DRAIN_IDLE_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  state_t                  state_q,     state_d;
  logic [RST_W-1:0]        rst_cnt_q,   rst_cnt_d;
  logic [COUNT_WIDTH-1:0]  timeout_q,   timeout_d;
  gecko_run_status_t       status_q,    status_d;
  logic [7:0]              exit_code_q, exit_code_d;

  logic                    start_fire;
  logic [COUNT_WIDTH-1:0]  cyc_count;
  logic [COUNT_WIDTH-1:0]  cyc_next;
  logic [IDLE_W-1:0]       idle_next;
  logic [IDLE_W-1:0]       idle_count_unused;
  gecko_run_result_t       result_w;

  assign start_fire = (state_q == ST_IDLE) && start_valid;

  // RUN-cycle counter; it is the result_cycles source, so it freezes
  // outside RUN and is only cleared when the next start is accepted.
  gecko_run_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_cycle_counter (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_fire),
    .load       (1'b0),
    .load_value ('0),
    .en         (state_q == ST_RUN),
    .count      (cyc_count),
    .count_next (cyc_next)
  );

  // Consecutive tty-idle cycles while draining; any tty activity restarts it.
  gecko_run_counter #(
    .WIDTH (IDLE_W)
  ) u_idle_counter (
    .clk        (clk),
    .rst        (rst),
    .clr        ((state_q != ST_DRAIN) || tty_out_valid),
    .load       (1'b0),
    .load_value ('0),
    .en         (state_q == ST_DRAIN),
    .count      (idle_count_unused),
    .count_next (idle_next)
  );

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    timeout_d   = timeout_q;
    status_d    = status_q;
    exit_code_d = exit_code_q;

    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          state_d     = ST_RESET;
          rst_cnt_d   = RST_W'(RESET_CYCLES);
          timeout_d   = start_timeout;
          status_d    = RUN_EXIT;
          exit_code_d = 8'h00;
        end
      end

      ST_RESET: begin
        if (abort) begin
          status_d = RUN_ABORTED;
          state_d  = ST_REPORT;
        end else if (rst_cnt_q == RST_W'(1)) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - RST_W'(1);
        end
      end

      ST_RUN: begin
        // cyc_next is the post-increment count of this RUN cycle.
        if (core_error_flag) begin
          status_d    = RUN_ERROR;
          exit_code_d = core_exit_code;
          state_d     = ST_DRAIN;
        end else if (core_exit_flag) begin
          status_d    = RUN_EXIT;
          exit_code_d = core_exit_code;
          state_d     = ST_DRAIN;
        end else if (abort) begin
          status_d = RUN_ABORTED;
          state_d  = ST_REPORT;
        end else if ((timeout_q != '0) && (cyc_next == timeout_q)) begin
          status_d = RUN_TIMEOUT;
          state_d  = ST_REPORT;
        end
      end

      ST_DRAIN: begin
        // Abort cuts the drain short but keeps the ERROR/EXIT status.
        if (abort || (idle_next == IDLE_W'(DRAIN_IDLE_CYCLES))) begin
          state_d = ST_REPORT;
        end
      end

      ST_REPORT: begin
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      timeout_q   <= '0;
      status_q    <= RUN_EXIT;
      exit_code_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      timeout_q   <= timeout_d;
      status_q    <= status_d;
      exit_code_q <= exit_code_d;
    end
  end

  // All outputs decode from state or registered fields only.
  assign start_ready  = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_REPORT);
  assign core_rst     = !((state_q == ST_RUN) || (state_q == ST_DRAIN));

  assign result_w.status    = status_q;
  assign result_w.exit_code = exit_code_q;
  assign result_w.cycles    = GECKO_RUN_CYCLES_W'(cyc_count);

  assign result_status    = result_w.status;
  assign result_exit_code = result_w.exit_code;
  assign result_cycles    = COUNT_WIDTH'(result_w.cycles);

endmodule

// File: tb/tb_gecko_run_controller.sv
// tb/tb_gecko_run_controller.sv - self-checking bench for gecko_run_controller

module tb_gecko_run_controller;
  import gecko_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] start_timeout;
  logic        abort;
  logic        core_rst;
  logic        core_exit_flag;
  logic        core_error_flag;
  logic [7:0]  core_exit_code;
  logic        tty_out_valid;
  logic        result_valid;
  logic        result_ready;
  logic [1:0]  result_status;
  logic [7:0]  result_exit_code;
  logic [31:0] result_cycles;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  gecko_run_result_t sb[$];

  gecko_run_controller #(
    .RESET_CYCLES      (16),
    .COUNT_WIDTH       (32),
    .DRAIN_IDLE_CYCLES (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_valid      (start_valid),
    .start_ready      (start_ready),
    .start_timeout    (start_timeout),
    .abort            (abort),
    .core_rst         (core_rst),
    .core_exit_flag   (core_exit_flag),
    .core_error_flag  (core_error_flag),
    .core_exit_code   (core_exit_code),
    .tty_out_valid    (tty_out_valid),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result_status    (result_status),
    .result_exit_code (result_exit_code),
    .result_cycles    (result_cycles),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1);
  end

  // Runs one program: start, count RESET cycles (core_rst=1, no result),
  // then count core_rst=0 cycles until result_valid. Events are driven in
  // low-cycle ev_cycle; tty is active for tty_len cycles after it.
  task automatic run_one(input logic [31:0] tmo, input int ev_cycle,
                         input logic ev_err, input logic ev_exit,
                         input logic [7:0] code, input int tty_len,
                         input int abort_rst_cycle,
                         output int rcyc, output int lcyc);
    int guard;
    rcyc = 0;
    lcyc = 0;
    guard = 0;
    start_valid   = 1'b1;
    start_timeout = tmo;
    @(negedge clk);
    start_valid = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || start_ready !== 1'b0) begin
      n_miss++;
      $display("FAIL start_accept: busy=%b start_ready=%b, required busy=1 start_ready=0", busy, start_ready);
    end
    while (core_rst === 1'b1 && result_valid !== 1'b1 && guard < 200) begin
      rcyc++;
      abort = (rcyc == abort_rst_cycle);
      @(negedge clk);
      guard++;
    end
    abort = 1'b0;
    while (result_valid !== 1'b1 && guard < 2000) begin
      lcyc++;
      core_error_flag = ev_err  && (lcyc == ev_cycle);
      core_exit_flag  = ev_exit && (lcyc == ev_cycle);
      core_exit_code  = (lcyc == ev_cycle) ? code : 8'h00;
      tty_out_valid   = (lcyc > ev_cycle) && (lcyc <= ev_cycle + tty_len);
      @(negedge clk);
      guard++;
    end
    core_error_flag = 1'b0;
    core_exit_flag  = 1'b0;
    core_exit_code  = 8'h00;
    tty_out_valid   = 1'b0;
    n_vec++;
    if (guard >= 2000) begin
      n_miss++;
      $display("FAIL run_bound: result_valid=%b after %0d cycles, required 1", result_valid, guard);
    end
  endtask

  // Holds result_ready low for 'hold' cycles (with core flags toggling, which
  // must be ignored), then handshakes and checks against the scoreboard.
  task automatic collect_result(input int hold);
    gecko_run_result_t exp;
    n_vec++;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL sb_empty: queue size 0, required an expected result");
      return;
    end
    exp = sb[0];
    for (int i = 0; i < hold; i++) begin
      result_ready    = 1'b0;
      core_error_flag = 1'b1;
      core_exit_flag  = 1'b1;
      core_exit_code  = 8'hFF;
      @(negedge clk);
      n_vec++;
      if (result_valid !== 1'b1 || start_ready !== 1'b0 || result_status !== exp.status ||
          result_exit_code !== exp.exit_code || result_cycles !== exp.cycles) begin
        n_miss++;
        $display("FAIL hold[%0d]: valid=%b ready=%b st=%0d code=%h cyc=%0d, required valid=1 ready=0 st=%0d code=%h cyc=%0d",
                 i, result_valid, start_ready, result_status, result_exit_code, result_cycles,
                 exp.status, exp.exit_code, exp.cycles);
      end
    end
    core_error_flag = 1'b0;
    core_exit_flag  = 1'b0;
    core_exit_code  = 8'h00;
    n_vec++;
    if (result_valid !== 1'b1) begin
      n_miss++;
      $display("FAIL result_valid: got %b, required 1", result_valid);
    end
    n_vec++;
    if (result_status !== exp.status) begin
      n_miss++;
      $display("FAIL status: got %0d, required %0d", result_status, exp.status);
    end
    n_vec++;
    if (result_exit_code !== exp.exit_code) begin
      n_miss++;
      $display("FAIL exit_code: got %h, required %h", result_exit_code, exp.exit_code);
    end
    n_vec++;
    if (result_cycles !== exp.cycles) begin
      n_miss++;
      $display("FAIL cycles: got %0d, required %0d", result_cycles, exp.cycles);
    end
    void'(sb.pop_front());
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    n_vec++;
    if (result_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0 ||
        result_status !== exp.status || result_cycles !== exp.cycles) begin
      n_miss++;
      $display("FAIL post_handshake: valid=%b ready=%b busy=%b st=%0d cyc=%0d, required 0 1 0 %0d %0d",
               result_valid, start_ready, busy, result_status, result_cycles, exp.status, exp.cycles);
    end
  endtask

  task automatic check_phase(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s: got %0d cycles, required %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start_valid = 1'b0; start_timeout = '0; abort = 1'b0;
    core_exit_flag = 1'b0; core_error_flag = 1'b0; core_exit_code = 8'h00;
    tty_out_valid = 1'b0; result_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (core_rst !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0 ||
        result_status !== 2'd0 || result_exit_code !== 8'h00 || result_cycles !== 32'd0) begin
      n_miss++;
      $display("FAIL reset_state: core_rst=%b busy=%b valid=%b st=%0d code=%h cyc=%0d, required 1 0 0 0 00 0",
               core_rst, busy, result_valid, result_status, result_exit_code, result_cycles);
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (start_ready !== 1'b1 || core_rst !== 1'b1) begin
      n_miss++;
      $display("FAIL reset_release: start_ready=%b core_rst=%b, required 1 1", start_ready, core_rst);
    end
  endtask

  task automatic test_normal_exit();
    int r, l;
    sb.push_back('{status: RUN_EXIT, exit_code: 8'h2A, cycles: 32'd100});
    run_one(32'd0, 100, 1'b0, 1'b1, 8'h2A, 0, 0, r, l);
    check_phase("exit_reset_len", r, 16);
    check_phase("exit_low_len", l, 104);
    collect_result(0);
  endtask

  task automatic test_timeout();
    int r, l;
    sb.push_back('{status: RUN_TIMEOUT, exit_code: 8'h00, cycles: 32'd50});
    run_one(32'd50, 0, 1'b0, 1'b0, 8'h00, 0, 0, r, l);
    check_phase("tmo_reset_len", r, 16);
    check_phase("tmo_low_len", l, 50);
    n_vec++;
    if (core_rst !== 1'b1) begin
      n_miss++;
      $display("FAIL tmo_core_rst: got %b, required 1", core_rst);
    end
    collect_result(0);
  endtask

  task automatic test_simultaneous();
    int r, l;
    sb.push_back('{status: RUN_ERROR, exit_code: 8'h07, cycles: 32'd20});
    run_one(32'd20, 20, 1'b1, 1'b1, 8'h07, 0, 0, r, l);
    check_phase("simul_low_len", l, 24);
    collect_result(0);
  endtask

  task automatic test_drain_extension();
    int r, l;
    sb.push_back('{status: RUN_EXIT, exit_code: 8'h11, cycles: 32'd10});
    run_one(32'd0, 10, 1'b0, 1'b1, 8'h11, 6, 0, r, l);
    check_phase("drain_low_len", l, 20);
    collect_result(0);
  endtask

  task automatic test_abort_backpressure();
    int r, l;
    sb.push_back('{status: RUN_ABORTED, exit_code: 8'h00, cycles: 32'd0});
    run_one(32'd0, 0, 1'b0, 1'b0, 8'h00, 0, 3, r, l);
    check_phase("abort_reset_len", r, 3);
    check_phase("abort_low_len", l, 0);
    collect_result(20);
  endtask

  task automatic test_back_to_back();
    int r, l;
    sb.push_back('{status: RUN_TIMEOUT, exit_code: 8'h00, cycles: 32'd5});
    run_one(32'd5, 0, 1'b0, 1'b0, 8'h00, 0, 0, r, l);
    check_phase("b2b_reset_len", r, 16);
    check_phase("b2b_low_len", l, 5);
    collect_result(0);
  endtask

  task automatic test_midrun_reset();
    int guard;
    guard = 0;
    start_valid = 1'b1;
    start_timeout = 32'd0;
    @(negedge clk);
    start_valid = 1'b0;
    while (core_rst === 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (core_rst !== 1'b0) begin
      n_miss++;
      $display("FAIL midrun_enter_run: core_rst=%b, required 0", core_rst);
    end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (core_rst !== 1'b1 || result_valid !== 1'b0 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL midrun_reset: core_rst=%b valid=%b busy=%b, required 1 0 0", core_rst, result_valid, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (start_ready !== 1'b1 || result_cycles !== 32'd0) begin
      n_miss++;
      $display("FAIL midrun_release: start_ready=%b cyc=%0d, required 1 0", start_ready, result_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_normal_exit();
    test_timeout();
    test_simultaneous();
    test_drain_extension();
    test_abort_backpressure();
    test_back_to_back();
    test_midrun_reset();
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL sb_leftover: %0d results pending, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
